// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronises rx_in, samples each bit mid-period and
// reassembles start/8-data/parity/stop frames into a byte with status flags.
`timescale 1ns/1ps
module uart_rx_deframer #(
  parameter int CLKS_PER_BIT = 1,
  parameter bit PARITY_ODD   = 1'b0,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam bit ONE_CLK = (CLKS_PER_BIT == 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [2:0]             idx;
  logic [7:0]             shift_reg;
  logic                   parity_bit;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;

  function automatic logic parity_of(input logic [7:0] d);
    return ^d;
  endfunction

  assign rx_s = sync[SYNC_STAGES-1];

  // Input synchroniser chain, preset to the idle-high line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '1;
    end else begin
      sync <= SYNC_STAGES'({sync, rx_in});
    end
  end

  // Frame FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= 3'd0;
      shift_reg  <= 8'h00;
      parity_bit <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            cnt     <= '0;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (cnt != HALF) begin
            cnt <= cnt + CW'(1);
          end else if (ONE_CLK) begin
            // One clock per bit: the low seen in IDLE already was the start
            // bit, so this cycle carries data bit 0.
            shift_reg[0] <= rx_s;
            idx          <= 3'd1;
            cnt          <= '0;
            state        <= DATA;
          end else if (!rx_s) begin
            state <= DATA;
            cnt   <= '0;
            idx   <= 3'd0;
          end else begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end
        DATA: begin
          if (cnt != LAST) begin
            cnt <= cnt + CW'(1);
          end else begin
            shift_reg[idx] <= rx_s;
            cnt            <= '0;
            if (idx == 3'd7) begin
              state <= PARITY;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        PARITY: begin
          if (cnt != LAST) begin
            cnt <= cnt + CW'(1);
          end else begin
            parity_bit <= rx_s;
            cnt        <= '0;
            state      <= STOP;
          end
        end
        STOP: begin
          if (cnt != LAST) begin
            cnt <= cnt + CW'(1);
          end else begin
            rx_data    <= shift_reg;
            parity_err <= parity_of(shift_reg) ^ parity_bit ^ PARITY_ODD;
            frame_err  <= ~rx_s;
            rx_valid   <= 1'b1;
            cnt        <= '0;
            if (rx_s) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              state <= WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Randomised bench for uart_rx_deframer: three instances (1, 4 and 8 clocks per
// bit) checked every cycle against a time-arithmetic frame model.
`timescale 1ns/1ps
module tb_uart_rx_deframer;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in_v    [NI];
  logic [7:0] rx_data_o  [NI];
  logic       rx_valid_o [NI];
  logic       perr_o     [NI];
  logic       ferr_o     [NI];
  logic       busy_o     [NI];

  always #5 clk = ~clk;

  function automatic int cpb_of(int i);
    return (i == 0) ? 1 : ((i == 1) ? 4 : 8);
  endfunction

  function automatic bit odd_of(int i);
    return (i == 2);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_rx_deframer #(
      .CLKS_PER_BIT(g == 0 ? 1 : (g == 1 ? 4 : 8)),
      .PARITY_ODD  (g == 2),
      .SYNC_STAGES (2)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_in     (rx_in_v[g]),
      .rx_data   (rx_data_o[g]),
      .rx_valid  (rx_valid_o[g]),
      .parity_err(perr_o[g]),
      .frame_err (ferr_o[g]),
      .rx_busy   (busy_o[g])
    );
  end

  // Reference model: a frame is anchored at the cycle the synchronised line is
  // first seen low while idle; every later sample time follows by arithmetic.
  int       cyc = 0;
  bit [1:0] m_sh    [NI];
  bit       m_frame [NI];
  bit       m_wait  [NI];
  int       m_t0    [NI];
  bit [7:0] m_d     [NI];
  bit       m_par   [NI];
  bit       e_valid [NI];
  bit [7:0] e_data  [NI];
  bit       e_perr  [NI];
  bit       e_ferr  [NI];
  bit       e_busy  [NI];

  function automatic void model_step(int i, bit rin, bit rr);
    int n, half, k, j, b;
    bit rs;
    n    = cpb_of(i);
    half = (n - 1) / 2;
    rs   = m_sh[i][1];
    if (rr) begin
      m_sh[i] = 2'b11; m_frame[i] = 1'b0; m_wait[i] = 1'b0;
      e_valid[i] = 1'b0; e_data[i] = 8'h00; e_perr[i] = 1'b0;
      e_ferr[i] = 1'b0; e_busy[i] = 1'b0;
      return;
    end
    e_valid[i] = 1'b0;
    if (!m_frame[i]) begin
      if (!rs) begin
        m_frame[i] = 1'b1; m_wait[i] = 1'b0; m_t0[i] = cyc;
      end
    end else if (m_wait[i]) begin
      if (rs) m_frame[i] = 1'b0;
    end else begin
      k = cyc - m_t0[i];
      j = k - ((n == 1) ? 1 : half + 1 + n);
      if (n > 1 && k == half + 1 && rs) begin
        m_frame[i] = 1'b0;
      end else if (j >= 0 && (j % n) == 0) begin
        b = j / n;
        if (b < 8) begin
          m_d[i][b] = rs;
        end else if (b == 8) begin
          m_par[i] = rs;
        end else begin
          e_valid[i] = 1'b1;
          e_data[i]  = m_d[i];
          e_perr[i]  = (^m_d[i]) ^ m_par[i] ^ odd_of(i);
          e_ferr[i]  = !rs;
          if (rs) m_frame[i] = 1'b0;
          else    m_wait[i]  = 1'b1;
        end
      end
    end
    e_busy[i] = m_frame[i];
    m_sh[i]   = {m_sh[i][0], rin};
  endfunction

  int         vectors = 0;
  int         miscompares = 0;
  bit         checking = 1'b0;
  int         vcnt [NI];
  int         vtimes [$];
  logic [7:0] vdata [$];

  // Per-cycle comparison of every instance against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        for (int i = 0; i < NI; i++) begin
          vectors++;
          if (rx_valid_o[i] !== e_valid[i] || rx_data_o[i] !== e_data[i] ||
              perr_o[i] !== e_perr[i] || ferr_o[i] !== e_ferr[i] ||
              busy_o[i] !== e_busy[i]) begin
            miscompares++;
            $display("FAIL outputs inst%0d cyc=%0d got v=%b d=%h pe=%b fe=%b busy=%b required v=%b d=%h pe=%b fe=%b busy=%b",
                     i, cyc, rx_valid_o[i], rx_data_o[i], perr_o[i], ferr_o[i], busy_o[i],
                     e_valid[i], e_data[i], e_perr[i], e_ferr[i], e_busy[i]);
          end
          if (rx_valid_o[i] === 1'b1) begin
            vcnt[i]++;
            if (i == 0) begin
              vtimes.push_back(cyc);
              vdata.push_back(rx_data_o[i]);
            end
          end
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < NI; i++) model_step(i, rx_in_v[i], rst);
    cyc++;
    #1;
  endtask

  task automatic hold(int i, bit v, int n);
    rx_in_v[i] = v;
    repeat (n) tick();
  endtask

  task automatic send_frame(int i, bit [7:0] d, bit bad_par, bit stop_v);
    int n;
    n = cpb_of(i);
    hold(i, 1'b0, n);
    for (int b = 0; b < 8; b++) hold(i, d[b], n);
    hold(i, (^d) ^ odd_of(i) ^ bad_par, n);
    hold(i, stop_v, n);
  endtask

  initial begin
    int b0;
    int n;
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      rx_in_v[i] = 1'b1;
      vcnt[i] = 0;
    end
    tick();
    checking = 1'b1;
    chk("reset_busy0", {31'd0, busy_o[0]}, 32'd0);
    chk("reset_data1", {24'd0, rx_data_o[1]}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    repeat (5) tick();

    // Single clean frame at one clock per bit.
    b0 = vcnt[0];
    send_frame(0, 8'hA5, 1'b0, 1'b1);
    hold(0, 1'b1, 6);
    chk("a5_count", vcnt[0], b0 + 1);
    chk("a5_data", {24'd0, rx_data_o[0]}, 32'hA5);
    chk("a5_perr", {31'd0, perr_o[0]}, 32'd0);
    chk("a5_ferr", {31'd0, ferr_o[0]}, 32'd0);

    // Parity error, then recovery on a good frame.
    send_frame(1, 8'h3C, 1'b1, 1'b1);
    hold(1, 1'b1, 6);
    chk("3c_data", {24'd0, rx_data_o[1]}, 32'h3C);
    chk("3c_perr", {31'd0, perr_o[1]}, 32'd1);
    chk("3c_ferr", {31'd0, ferr_o[1]}, 32'd0);
    send_frame(1, 8'h01, 1'b0, 1'b1);
    hold(1, 1'b1, 6);
    chk("01_perr", {31'd0, perr_o[1]}, 32'd0);

    // Framing error with a held-low line, then a clean frame.
    b0 = vcnt[1];
    send_frame(1, 8'hFF, 1'b0, 1'b0);
    hold(1, 1'b0, 10);
    chk("ff_count", vcnt[1], b0 + 1);
    chk("ff_ferr", {31'd0, ferr_o[1]}, 32'd1);
    chk("ff_busy_low", {31'd0, busy_o[1]}, 32'd1);
    hold(1, 1'b1, 6);
    chk("ff_busy_high", {31'd0, busy_o[1]}, 32'd0);
    send_frame(1, 8'h55, 1'b0, 1'b1);
    hold(1, 1'b1, 6);
    chk("55_count", vcnt[1], b0 + 2);
    chk("55_data", {24'd0, rx_data_o[1]}, 32'h55);
    chk("55_ferr", {31'd0, ferr_o[1]}, 32'd0);

    // False start at eight clocks per bit leaves earlier flags intact.
    send_frame(2, 8'hC3, 1'b1, 1'b1);
    hold(2, 1'b1, 8);
    chk("c3_perr", {31'd0, perr_o[2]}, 32'd1);
    b0 = vcnt[2];
    hold(2, 1'b0, 2);
    hold(2, 1'b1, 20);
    chk("glitch_count", vcnt[2], b0);
    chk("glitch_data", {24'd0, rx_data_o[2]}, 32'hC3);
    chk("glitch_perr", {31'd0, perr_o[2]}, 32'd1);
    chk("glitch_busy", {31'd0, busy_o[2]}, 32'd0);

    // Back-to-back frames with no idle gap.
    b0 = vtimes.size();
    send_frame(0, 8'h00, 1'b0, 1'b1);
    send_frame(0, 8'hFF, 1'b0, 1'b1);
    send_frame(0, 8'h81, 1'b0, 1'b1);
    hold(0, 1'b1, 6);
    chk("b2b_count", vtimes.size(), b0 + 3);
    if (vtimes.size() == b0 + 3) begin
      chk("b2b_gap1", vtimes[b0 + 1] - vtimes[b0], 11);
      chk("b2b_gap2", vtimes[b0 + 2] - vtimes[b0 + 1], 11);
      chk("b2b_d0", {24'd0, vdata[b0]}, 32'h00);
      chk("b2b_d1", {24'd0, vdata[b0 + 1]}, 32'hFF);
      chk("b2b_d2", {24'd0, vdata[b0 + 2]}, 32'h81);
    end

    // Reset in the middle of data bit 4.
    b0 = vcnt[1];
    hold(1, 1'b0, 4);
    for (int b = 0; b < 4; b++) hold(1, b[0] ? 1'b1 : 1'b0, 4);
    hold(1, 1'b1, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy_o[1]}, 32'd0);
    chk("rst_data", {24'd0, rx_data_o[1]}, 32'd0);
    chk("rst_valid", {31'd0, rx_valid_o[1]}, 32'd0);
    chk("rst_perr", {31'd0, perr_o[1]}, 32'd0);
    hold(1, 1'b1, 30);
    chk("rst_count", vcnt[1], b0);
    send_frame(1, 8'h96, 1'b0, 1'b1);
    hold(1, 1'b1, 6);
    chk("96_data", {24'd0, rx_data_o[1]}, 32'h96);
    chk("96_perr", {31'd0, perr_o[1]}, 32'd0);

    // Randomised frames, errors, gaps and short glitches.
    for (int it = 0; it < 60; it++) begin
      int  i;
      bit  bp, sv;
      bit [7:0] d;
      i  = $urandom_range(0, NI - 1);
      n  = cpb_of(i);
      d  = 8'($urandom);
      bp = ($urandom_range(0, 3) == 0);
      sv = ($urandom_range(0, 5) != 0);
      if (n > 1 && $urandom_range(0, 4) == 0) begin
        hold(i, 1'b0, $urandom_range(1, (n - 1) / 2 + 1));
        hold(i, 1'b1, 2 * n + 2);
      end
      send_frame(i, d, bp, sv);
      if (!sv) hold(i, 1'b0, $urandom_range(0, 2 * n));
      hold(i, 1'b1, sv ? $urandom_range(0, 2 * n) : $urandom_range(1, 2 * n));
    end
    for (int i = 0; i < NI; i++) rx_in_v[i] = 1'b1;
    repeat (30) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
